// File: rtl/seq_arbiter.sv
// seq_arbiter: round-robin arbiter serializing a two-phase output sequence; SEQ_ARB_SERVED_CNT_EN adds SERVED_CNT.
module seq_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PHASE_LEN = 1,
  parameter int IDW       = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [IDW-1:0]     GNT_ID,
  output logic               BUSY,
  output logic               OUT_SIG_1,
  output logic               OUT_SIG_2,
  output logic               DONE
`ifdef SEQ_ARB_SERVED_CNT_EN
  ,output logic [7:0]        SERVED_CNT
`endif
);
  localparam logic [7:0] LAST = 8'((PHASE_LEN < 2 ? 1 : PHASE_LEN) - 1);
  typedef enum logic [1:0] {IDLE, PHASE_1, PHASE_2, DONE_ST} state_t;
  state_t state, n_state;
  logic [7:0] cnt, n_cnt;
  logic [IDW-1:0] ptr, n_ptr, win, off, n_id;
  logic [IDW:0] sum;
  logic [NUM_REQ-1:0] rot, n_gnt;
  logic n_busy, n_o1, n_o2, n_done;
  // rotate so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    rot = NUM_REQ'({REQ, REQ} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = IDW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = sum >= (IDW+1)'(NUM_REQ) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
  end
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_ptr   = ptr;
    n_gnt   = GNT;
    n_id    = GNT_ID;
    n_busy  = BUSY;
    n_o1    = OUT_SIG_1;
    n_o2    = OUT_SIG_2;
    n_done  = DONE;
    case (state)
      IDLE: if (|REQ) begin
        n_state = PHASE_1;
        n_gnt   = NUM_REQ'(1) << win;
        n_id    = win;
        n_busy  = 1'b1;
        n_o1    = 1'b1;
        n_cnt   = LAST;
      end
      PHASE_1: begin
        n_cnt   = cnt == 8'd0 ? LAST : cnt - 8'd1;
        n_o2    = cnt == 8'd0;
        n_state = cnt == 8'd0 ? PHASE_2 : PHASE_1;
      end
      PHASE_2: if (cnt == 8'd0) begin
        n_state = DONE_ST;
        n_o1    = 1'b0;
        n_o2    = 1'b0;
        n_gnt   = '0;
        n_busy  = 1'b0;
        n_done  = 1'b1;
        n_ptr   = GNT_ID == IDW'(NUM_REQ - 1) ? '0 : GNT_ID + IDW'(1);
      end else n_cnt = cnt - 8'd1;
      DONE_ST: begin
        n_done  = 1'b0;
        n_state = IDLE;
      end
      default: begin
        n_state = IDLE;
        n_cnt   = '0;
        n_gnt   = '0;
        n_id    = '0;
        n_busy  = 1'b0;
        n_o1    = 1'b0;
        n_o2    = 1'b0;
        n_done  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      GNT       <= '0;
      GNT_ID    <= '0;
      BUSY      <= 1'b0;
      OUT_SIG_1 <= 1'b0;
      OUT_SIG_2 <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= n_state;
      cnt       <= n_cnt;
      ptr       <= n_ptr;
      GNT       <= n_gnt;
      GNT_ID    <= n_id;
      BUSY      <= n_busy;
      OUT_SIG_1 <= n_o1;
      OUT_SIG_2 <= n_o2;
      DONE      <= n_done;
    end
  end
`ifdef SEQ_ARB_SERVED_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET) SERVED_CNT <= '0;
    else if (state == PHASE_2 && cnt == 8'd0) SERVED_CNT <= SERVED_CNT + 8'd1;
  end
`endif
endmodule

// File: tb/tb_seq_arbiter.sv
// tb_seq_arbiter: scoreboard bench for seq_arbiter with PHASE_LEN 1, 2 and 3 instances.
module tb_seq_arbiter;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int tests = 0, fails = 0;
  int exp_q[$];
  logic rst1, rst2, rst3;
  logic [3:0] req1, req2, req3, gnt1, gnt2, gnt3;
  logic [1:0] id1, id2, id3;
  logic busy1, busy2, busy3, sa1, sa2, sa3, sb1, sb2, sb3, done1, done2, done3;
`ifdef SEQ_ARB_SERVED_CNT_EN
  logic [7:0] sc1, sc2, sc3;
`endif
  seq_arbiter #(.NUM_REQ(4), .PHASE_LEN(1), .IDW(2)) u1 (.CLK(CLK), .RESET(rst1), .REQ(req1), .GNT(gnt1),
    .GNT_ID(id1), .BUSY(busy1), .OUT_SIG_1(sa1), .OUT_SIG_2(sb1), .DONE(done1)
`ifdef SEQ_ARB_SERVED_CNT_EN
    , .SERVED_CNT(sc1)
`endif
  );
  seq_arbiter #(.NUM_REQ(4), .PHASE_LEN(2), .IDW(2)) u2 (.CLK(CLK), .RESET(rst2), .REQ(req2), .GNT(gnt2),
    .GNT_ID(id2), .BUSY(busy2), .OUT_SIG_1(sa2), .OUT_SIG_2(sb2), .DONE(done2)
`ifdef SEQ_ARB_SERVED_CNT_EN
    , .SERVED_CNT(sc2)
`endif
  );
  seq_arbiter #(.NUM_REQ(4), .PHASE_LEN(3), .IDW(2)) u3 (.CLK(CLK), .RESET(rst3), .REQ(req3), .GNT(gnt3),
    .GNT_ID(id3), .BUSY(busy3), .OUT_SIG_1(sa3), .OUT_SIG_2(sb3), .DONE(done3)
`ifdef SEQ_ARB_SERVED_CNT_EN
    , .SERVED_CNT(sc3)
`endif
  );
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    {rst1, rst2, rst3} = 3'b111;
    {req1, req2, req3} = '0;
    tick;
    tests++;
    if ({gnt1, id1, busy1, sa1, sb1, done1, gnt2, id2, busy2, sa2, sb2, done2, gnt3, id3, busy3, sa3, sb3, done3} !== '0) begin
      fails++;
      $display("FAIL reset_values: got u1=%b u2=%b u3=%b want all 0", {gnt1, id1, busy1, sa1, sb1, done1},
               {gnt2, id2, busy2, sa2, sb2, done2}, {gnt3, id3, busy3, sa3, sb3, done3});
    end
    {rst1, rst2, rst3} = 3'b000;
    for (int c = 0; c < 10; c++) begin
      tick;
      tests++;
      if ({gnt1, id1, busy1, sa1, sb1, done1} !== '0) begin
        fails++;
        $display("FAIL idle_quiet cyc %0d: got %b want 0", c, {gnt1, id1, busy1, sa1, sb1, done1});
      end
    end
  endtask
  task automatic test_single;
    int e;
    exp_q.push_back(0);
    req1 = 4'b0001;
    tick;
    req1 = 4'b0000;
    e = exp_q.pop_front();
    tests++;
    if (gnt1 !== 4'b0001 || id1 !== 2'(e) || sa1 !== 1'b1 || sb1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL single_edge1: got gnt=%b id=%0d s1=%b s2=%b busy=%b done=%b want 0001 %0d 1 0 1 0",
               gnt1, id1, sa1, sb1, busy1, done1, e);
    end
    tick;
    tests++;
    if (sa1 !== 1'b1 || sb1 !== 1'b1 || gnt1 !== 4'b0001) begin
      fails++;
      $display("FAIL single_edge2: got s1=%b s2=%b gnt=%b want 1 1 0001", sa1, sb1, gnt1);
    end
    tick;
    tests++;
    if ({gnt1, busy1, sa1, sb1} !== '0 || done1 !== 1'b1 || id1 !== 2'd0) begin
      fails++;
      $display("FAIL single_edge3: got gnt=%b busy=%b s1=%b s2=%b done=%b id=%0d want 0000 0 0 0 1 0",
               gnt1, busy1, sa1, sb1, done1, id1);
    end
    tick;
    tests++;
    if (done1 !== 1'b0) begin
      fails++;
      $display("FAIL single_edge4: got done=%b want 0", done1);
    end
    for (int c = 0; c < 6; c++) begin
      tick;
      tests++;
      if (gnt1 !== 4'b0000 || done1 !== 1'b0) begin
        fails++;
        $display("FAIL single_no_regrant cyc %0d: got gnt=%b done=%b want 0000 0", c, gnt1, done1);
      end
    end
  endtask
  task automatic test_round_robin;
    int last, grants, dones, c1, c2, e, lastid;
    logic [3:0] pg;
    last = -1;
    grants = 0;
    dones = 0;
    c1 = 0;
    c2 = 0;
    lastid = 0;
    pg = '0;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req3 = 4'hf;
    for (int cyc = 0; cyc < 80 && dones < 5; cyc++) begin
      tick;
      if (sa3) c1++;
      if (sb3) c2++;
      if (gnt3 !== 4'b0000 && pg === 4'b0000) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
        tests++;
        if (e < 0 || id3 !== 2'(e) || gnt3 !== (4'b0001 << e)) begin
          fails++;
          $display("FAIL rr_order grant %0d: got id=%0d gnt=%b want id=%0d", grants, id3, gnt3, e);
        end
        if (last >= 0) begin
          tests++;
          if (cyc - last != 8) begin
            fails++;
            $display("FAIL rr_spacing grant %0d: got %0d cycles want 8", grants, cyc - last);
          end
        end
        last = cyc;
        lastid = e;
        grants++;
        if (grants == 5) req3 = 4'b0000;
      end
      if (done3) begin
        dones++;
        tests++;
        if (c1 != 6 || c2 != 3 || gnt3 !== 4'b0000 || busy3 !== 1'b0 || id3 !== 2'(lastid)) begin
          fails++;
          $display("FAIL rr_done %0d: got s1=%0d s2=%0d gnt=%b busy=%b id=%0d want 6 3 0000 0 %0d",
                   dones, c1, c2, gnt3, busy3, id3, lastid);
        end
        c1 = 0;
        c2 = 0;
      end
      pg = gnt3;
    end
    tests++;
    if (dones != 5 || grants != 5 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rr_timeout: got grants=%0d dones=%0d pending=%0d want 5 5 0", grants, dones, exp_q.size());
    end
  endtask
  task automatic test_no_preempt;
    int n, e;
    exp_q.push_back(2);
    req2 = 4'b0100;
    tick;
    e = exp_q.pop_front();
    tests++;
    if (gnt2 !== 4'b0100 || id2 !== 2'(e) || sa2 !== 1'b1) begin
      fails++;
      $display("FAIL np_grant: got gnt=%b id=%0d s1=%b want 0100 %0d 1", gnt2, id2, sa2, e);
    end
    req2 = 4'b0001;
    n = 0;
    while (!done2 && n < 10) begin
      tick;
      n++;
      tests++;
      if (!done2 && (gnt2 !== 4'b0100 || id2 !== 2'd2)) begin
        fails++;
        $display("FAIL np_hold cyc %0d: got gnt=%b id=%0d want 0100 2", n, gnt2, id2);
      end
    end
    tests++;
    if (n != 4 || done2 !== 1'b1) begin
      fails++;
      $display("FAIL np_done_latency: got %0d edges done=%b want 4 1", n, done2);
    end
    exp_q.push_back(0);
    tick;
    tests++;
    if (gnt2 !== 4'b0000 || done2 !== 1'b0) begin
      fails++;
      $display("FAIL np_done_st: got gnt=%b done=%b want 0000 0", gnt2, done2);
    end
    tick;
    e = exp_q.pop_front();
    tests++;
    if (gnt2 !== 4'b0001 || id2 !== 2'(e)) begin
      fails++;
      $display("FAIL np_next_grant: got gnt=%b id=%0d want 0001 %0d", gnt2, id2, e);
    end
    req2 = 4'b0000;
    n = 0;
    while (!done2 && n < 10) begin
      tick;
      n++;
    end
    tests++;
    if (done2 !== 1'b1) begin
      fails++;
      $display("FAIL np_finish_timeout: got done=%b want 1", done2);
    end
    tick;
  endtask
  task automatic test_reset_mid;
    int n, e;
    exp_q.push_back(1);
    req2 = 4'b0011;
    tick;
    e = exp_q.pop_front();
    tests++;
    if (gnt2 !== 4'b0010 || id2 !== 2'(e)) begin
      fails++;
      $display("FAIL rm_grant: got gnt=%b id=%0d want 0010 %0d", gnt2, id2, e);
    end
    tick;
    tick;
    tests++;
    if (sb2 !== 1'b1 || gnt2 !== 4'b0010) begin
      fails++;
      $display("FAIL rm_phase2: got s2=%b gnt=%b want 1 0010", sb2, gnt2);
    end
    rst2 = 1'b1;
    tick;
    tests++;
    if ({gnt2, id2, busy2, sa2, sb2, done2} !== '0) begin
      fails++;
      $display("FAIL rm_cleared: got %b want 0", {gnt2, id2, busy2, sa2, sb2, done2});
    end
    rst2 = 1'b0;
    exp_q.push_back(0);
    tick;
    e = exp_q.pop_front();
    tests++;
    if (gnt2 !== 4'b0001 || id2 !== 2'(e) || done2 !== 1'b0) begin
      fails++;
      $display("FAIL rm_first_grant: got gnt=%b id=%0d done=%b want 0001 %0d 0", gnt2, id2, done2, e);
    end
    req2 = 4'b0000;
    n = 0;
    while (!done2 && n < 10) begin
      tick;
      n++;
    end
    tests++;
    if (done2 !== 1'b1) begin
      fails++;
      $display("FAIL rm_finish_timeout: got done=%b want 1", done2);
    end
    tick;
  endtask
`ifdef SEQ_ARB_SERVED_CNT_EN
  task automatic test_served_cnt;
    int e, n, dones;
    rst1 = 1'b1;
    tick;
    rst1 = 1'b0;
    tests++;
    if (sc1 !== 8'd0) begin
      fails++;
      $display("FAIL sc_reset: got %0d want 0", sc1);
    end
    e = 0;
    n = 0;
    dones = 0;
    req1 = 4'b0001;
    while (dones < 257 && n < 1500) begin
      tick;
      n++;
      if (done1) begin
        dones++;
        e = (e + 1) % 256;
        tests++;
        if (sc1 !== 8'(e)) begin
          fails++;
          $display("FAIL sc_step %0d: got %0d want %0d", dones, sc1, e);
        end
      end
    end
    req1 = 4'b0000;
    tests++;
    if (dones != 257 || sc1 !== 8'd1) begin
      fails++;
      $display("FAIL sc_final: got dones=%0d cnt=%0d want 257 1", dones, sc1);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_no_preempt;
    test_reset_mid;
`ifdef SEQ_ARB_SERVED_CNT_EN
    test_served_cnt;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
